// File: rtl/sparc_mul_mac_pipe.sv
// Pipelined multiply-accumulate unit shared by EXU and SPU. A round-robin arbiter issues one op per cycle.
// SPU accumulator ops are applied in issue order at the final stage, so back-to-back MACs need no bypass.
module sparc_mul_mac_pipe #(
  parameter int WIDTH = 64,
  parameter int LAT   = 5,
  parameter int GUARD = 8
) (
  input  logic               rclk,
  input  logic               rst_l,
  input  logic               exu_mul_req,
  input  logic               exu_mul_signed,
  input  logic [WIDTH-1:0]   exu_mul_rs1,
  input  logic [WIDTH-1:0]   exu_mul_rs2,
  output logic               mul_exu_ack,
  input  logic               spu_mul_req,
  input  logic [2:0]         spu_mul_op,
  input  logic [WIDTH-1:0]   spu_mul_op1,
  input  logic [WIDTH-1:0]   spu_mul_op2,
  output logic               mul_spu_ack,
  output logic               mul_exu_vld,
  output logic               mul_spu_vld,
  output logic [2*WIDTH-1:0] mul_data_out,
  output logic               mul_acc_ovf,
  output logic               mul_busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int ACCW = PW + GUARD;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MAC   = 3'b001;
  localparam logic [2:0] OP_MACX2 = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_CLR   = 3'b100;

  logic last_spu_q, last_spu_d;
  logic gnt_exu, gnt_spu;

  logic             vld_q [1:LAT-1];
  logic             spu_q [1:LAT-1];
  logic [2:0]       op_q  [1:LAT-1];
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;

  logic signed [PW-1:0] mul_a, mul_b, prod_s1;
  logic [PW-1:0]        fin_prod;

  logic            fin_vld, fin_spu;
  logic [2:0]      fin_op;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW:0]   sum;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   dout_q, dout_d;
  logic            exu_vld_q, exu_vld_d, spu_vld_q, spu_vld_d;
  logic            busy_any;

  // Arbiter: on contention the requester not granted last wins
  always_comb begin
    gnt_exu    = exu_mul_req & (~spu_mul_req | last_spu_q);
    gnt_spu    = spu_mul_req & ~gnt_exu;
    last_spu_d = last_spu_q;
    if (gnt_spu)
      last_spu_d = 1'b1;
    else if (gnt_exu)
      last_spu_d = 1'b0;
  end

  assign mul_exu_ack = gnt_exu & rst_l;
  assign mul_spu_ack = gnt_spu & rst_l;

  // Stage 1: operand capture
  always_ff @(posedge rclk) begin
    a_q    <= gnt_spu ? spu_mul_op1 : exu_mul_rs1;
    b_q    <= gnt_spu ? spu_mul_op2 : exu_mul_rs2;
    sgn_q  <= gnt_exu & exu_mul_signed;
    spu_q[1] <= gnt_spu;
    op_q[1]  <= gnt_spu ? spu_mul_op : OP_MUL;
    for (int k = 2; k <= LAT - 1; k++) begin
      spu_q[k] <= spu_q[k-1];
      op_q[k]  <= op_q[k-1];
    end
  end

  // Sign-extending to full product width lets one signed multiplier serve both modes
  always_comb begin
    mul_a   = $signed({{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q});
    mul_b   = $signed({{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q});
    prod_s1 = mul_a * mul_b;
  end

  // Stages 2..LAT-1: registered product delay line
  generate
    if (LAT > 2) begin : g_prod
      logic [PW-1:0] prod_q [2:LAT-1];
      always_ff @(posedge rclk) begin
        prod_q[2] <= prod_s1;
        for (int k = 3; k <= LAT - 1; k++)
          prod_q[k] <= prod_q[k-1];
      end
      assign fin_prod = prod_q[LAT-1];
    end else begin : g_prod_comb
      assign fin_prod = prod_s1;
    end
  endgenerate

  assign fin_vld = vld_q[LAT-1];
  assign fin_spu = spu_q[LAT-1];
  assign fin_op  = op_q[LAT-1];

  // Final stage: accumulator update and result selection
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    dout_d    = dout_q;
    sum       = '0;
    exu_vld_d = fin_vld & ~fin_spu;
    spu_vld_d = fin_vld & fin_spu;
    if (fin_vld) begin
      dout_d = fin_prod;
      if (fin_spu) begin
        case (fin_op)
          OP_MAC, OP_MACX2: begin
            if (fin_op == OP_MAC)
              sum = {1'b0, acc_q} + {{(GUARD + 1){1'b0}}, fin_prod};
            else
              sum = {1'b0, acc_q} + {{GUARD{1'b0}}, fin_prod, 1'b0};
            acc_d  = sum[ACCW-1:0];
            ovf_d  = ovf_q | sum[ACCW];
            dout_d = sum[PW-1:0];
          end
          OP_SHR: begin
            dout_d = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
            acc_d  = acc_q >> WIDTH;
          end
          OP_CLR: begin
            dout_d = '0;
            acc_d  = '0;
            ovf_d  = 1'b0;
          end
          default: dout_d = fin_prod;
        endcase
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      last_spu_q <= 1'b1;
      for (int k = 1; k <= LAT - 1; k++)
        vld_q[k] <= 1'b0;
      exu_vld_q <= 1'b0;
      spu_vld_q <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      last_spu_q <= last_spu_d;
      vld_q[1]   <= gnt_exu | gnt_spu;
      for (int k = 2; k <= LAT - 1; k++)
        vld_q[k] <= vld_q[k-1];
      exu_vld_q <= exu_vld_d;
      spu_vld_q <= spu_vld_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    busy_any = exu_vld_q | spu_vld_q;
    for (int k = 1; k <= LAT - 1; k++)
      busy_any = busy_any | vld_q[k];
  end

  assign mul_exu_vld  = exu_vld_q & rst_l;
  assign mul_spu_vld  = spu_vld_q & rst_l;
  assign mul_busy     = busy_any & rst_l;
  assign mul_data_out = rst_l ? dout_q : '0;
  assign mul_acc_ovf  = ovf_q;

endmodule

// File: tb/tb_sparc_mul_mac_pipe.sv
// Self-checking bench for sparc_mul_mac_pipe: scoreboard of results queued at ack, checked at strobe.
module tb_sparc_mul_mac_pipe;
  localparam int W    = 64;
  localparam int LAT  = 5;
  localparam int G    = 8;
  localparam int PW   = 2 * W;
  localparam int ACCW = PW + G;

  logic          rclk, rst_l;
  logic          exu_mul_req, exu_mul_signed;
  logic [W-1:0]  exu_mul_rs1, exu_mul_rs2;
  logic          mul_exu_ack;
  logic          spu_mul_req;
  logic [2:0]    spu_mul_op;
  logic [W-1:0]  spu_mul_op1, spu_mul_op2;
  logic          mul_spu_ack, mul_exu_vld, mul_spu_vld;
  logic [PW-1:0] mul_data_out;
  logic          mul_acc_ovf, mul_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic          spu;
    logic [PW-1:0] data;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [ACCW-1:0] m_acc;
  logic            m_ovf;

  sparc_mul_mac_pipe #(.WIDTH(W), .LAT(LAT), .GUARD(G)) dut (
    .rclk(rclk), .rst_l(rst_l),
    .exu_mul_req(exu_mul_req), .exu_mul_signed(exu_mul_signed),
    .exu_mul_rs1(exu_mul_rs1), .exu_mul_rs2(exu_mul_rs2), .mul_exu_ack(mul_exu_ack),
    .spu_mul_req(spu_mul_req), .spu_mul_op(spu_mul_op),
    .spu_mul_op1(spu_mul_op1), .spu_mul_op2(spu_mul_op2), .mul_spu_ack(mul_spu_ack),
    .mul_exu_vld(mul_exu_vld), .mul_spu_vld(mul_spu_vld), .mul_data_out(mul_data_out),
    .mul_acc_ovf(mul_acc_ovf), .mul_busy(mul_busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    logic signed [PW-1:0] sa, sbv;
    logic [PW-1:0] ua, ub;
    if (sg) begin
      sa  = $signed(a);
      sbv = $signed(b);
      return sa * sbv;
    end
    ua = PW'(a);
    ub = PW'(b);
    return ua * ub;
  endfunction

  // Scoreboard: push expectation at ack, compare at strobe
  always @(negedge rclk) begin
    exp_t e;
    logic [PW-1:0] p;
    logic [ACCW:0] msum;
    if (!rst_l) begin
      sb.delete();
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      if (mul_exu_vld || mul_spu_vld) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe exu=%0b spu=%0b data=%h required=no strobe", mul_exu_vld, mul_spu_vld, mul_data_out);
        end else begin
          e = sb.pop_front();
          if (mul_spu_vld !== e.spu || mul_exu_vld !== ~e.spu || mul_data_out !== e.data ||
              mul_acc_ovf !== e.ovf || cyc != e.cyc + LAT) begin
            fails++;
            $display("FAIL scoreboard got spu=%0b data=%h ovf=%0b cyc=%0d required spu=%0b data=%h ovf=%0b cyc=%0d",
                     mul_spu_vld, mul_data_out, mul_acc_ovf, cyc, e.spu, e.data, e.ovf, e.cyc + LAT);
          end
        end
      end
      if (mul_exu_ack && mul_spu_ack) begin
        tests++;
        fails++;
        $display("FAIL dual_ack got exu=1 spu=1 required at most one");
      end
      if (mul_exu_ack) begin
        e.spu  = 1'b0;
        e.data = ref_mul(exu_mul_rs1, exu_mul_rs2, exu_mul_signed);
        e.ovf  = m_ovf;
        e.cyc  = cyc;
        sb.push_back(e);
      end
      if (mul_spu_ack) begin
        p = ref_mul(spu_mul_op1, spu_mul_op2, 1'b0);
        case (spu_mul_op)
          3'b001, 3'b010: begin
            if (spu_mul_op == 3'b001) msum = {1'b0, m_acc} + (ACCW+1)'(p);
            else                      msum = {1'b0, m_acc} + (ACCW+1)'(p) * 2;
            m_acc  = msum[ACCW-1:0];
            m_ovf  = m_ovf | msum[ACCW];
            e.data = m_acc[PW-1:0];
          end
          3'b011: begin
            e.data = {{W{1'b0}}, m_acc[W-1:0]};
            m_acc  = m_acc >> W;
          end
          3'b100: begin
            e.data = '0;
            m_acc  = '0;
            m_ovf  = 1'b0;
          end
          default: e.data = p;
        endcase
        e.spu = 1'b1;
        e.ovf = m_ovf;
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic next_cycle();
    @(posedge rclk);
    #1;
  endtask

  task automatic set_idle();
    exu_mul_req = 1'b0;
    spu_mul_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge rclk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    repeat (2) @(negedge rclk);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    exu_mul_req = 1'b1;
    spu_mul_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      tests++;
      if ({mul_exu_ack, mul_spu_ack, mul_exu_vld, mul_spu_vld, mul_busy} !== 5'b0 || mul_data_out !== '0) begin
        fails++;
        $display("FAIL reset_outputs got ack=%0b%0b vld=%0b%0b busy=%0b data=%h required all 0",
                 mul_exu_ack, mul_spu_ack, mul_exu_vld, mul_spu_vld, mul_busy, mul_data_out);
      end
    end
    next_cycle();
    rst_l = 1'b1;
    set_idle();
    @(negedge rclk);
    tests++;
    if (mul_data_out !== '0 || mul_acc_ovf !== 1'b0 || mul_busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got data=%h ovf=%0b busy=%0b required 0/0/0", mul_data_out, mul_acc_ovf, mul_busy);
    end
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      exu_mul_req = 1'b1; exu_mul_signed = 1'b0;
      exu_mul_rs1 = W'(i + 1); exu_mul_rs2 = W'(10 + i);
      spu_mul_req = 1'b1; spu_mul_op = 3'b000;
      spu_mul_op1 = W'(100 + i); spu_mul_op2 = W'(3);
      @(negedge rclk);
      tests++;
      if (mul_exu_ack !== (i % 2 == 0) || mul_spu_ack !== (i % 2 != 0)) begin
        fails++;
        $display("FAIL arb_alternate i=%0d got exu=%0b spu=%0b required exu=%0b", i, mul_exu_ack, mul_spu_ack, i % 2 == 0);
      end
    end
    next_cycle();
    exu_mul_req = 1'b1; spu_mul_req = 1'b0;
    next_cycle();
    set_idle();
    repeat (3) next_cycle();
    exu_mul_req = 1'b1; spu_mul_req = 1'b1;
    @(negedge rclk);
    tests++;
    if (mul_exu_ack !== 1'b0 || mul_spu_ack !== 1'b1) begin
      fails++;
      $display("FAIL arb_pointer_hold got exu=%0b spu=%0b required exu=0 spu=1", mul_exu_ack, mul_spu_ack);
    end
    next_cycle();
    set_idle();
    wait_drain();
  endtask

  task automatic test_basic();
    next_cycle();
    exu_mul_req = 1'b1; exu_mul_signed = 1'b0;
    exu_mul_rs1 = 64'd3; exu_mul_rs2 = 64'd5;
    @(negedge rclk);
    tests++;
    if (mul_exu_ack !== 1'b1) begin
      fails++;
      $display("FAIL basic_ack got %0b required 1", mul_exu_ack);
    end
    next_cycle();
    set_idle();
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge rclk);
      tests++;
      if (mul_busy !== (k <= LAT) || mul_exu_vld !== (k == LAT) || (k == LAT && mul_data_out !== 128'd15)) begin
        fails++;
        $display("FAIL basic_timing k=%0d got busy=%0b vld=%0b data=%h required busy=%0b vld=%0b data=15",
                 k, mul_busy, mul_exu_vld, mul_data_out, k <= LAT, k == LAT);
      end
    end
    wait_drain();
  endtask

  task automatic test_signed();
    logic [PW-1:0] got [2];
    int n = 0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      exu_mul_req = 1'b1; exu_mul_signed = (i == 0);
      exu_mul_rs1 = '1; exu_mul_rs2 = 64'd2;
      @(negedge rclk);
      tests++;
      if (mul_exu_ack !== 1'b1) begin
        fails++;
        $display("FAIL signed_ack i=%0d got %0b required 1", i, mul_exu_ack);
      end
    end
    next_cycle();
    set_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (mul_exu_vld && n < 2) begin
        got[n] = mul_data_out;
        n++;
      end
    end
    tests++;
    if (n != 2 || got[0] !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE ||
        got[1] !== 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE) begin
      fails++;
      $display("FAIL signed_products got n=%0d %h %h required 2 results -2 and 1_FFFF..FFFE", n, got[0], got[1]);
    end
    wait_drain();
  endtask

  task automatic test_accum();
    logic [2:0]    ops [5];
    logic [W-1:0]  o1 [5];
    logic [W-1:0]  o2 [5];
    logic [PW-1:0] expd [5];
    int n = 0;
    ops = '{3'b100, 3'b001, 3'b010, 3'b011, 3'b011};
    o1  = '{64'd0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd0};
    o2  = '{64'd0, 64'd4, 64'd1, 64'd0, 64'd0};
    expd = '{128'd0, 128'h2_0000_0000_0000_0000, 128'h2_0000_0000_0000_0002, 128'd2, 128'd2};
    for (int i = 0; i < 5 + LAT + 3; i++) begin
      next_cycle();
      if (i < 5) begin
        spu_mul_req = 1'b1; spu_mul_op = ops[i]; spu_mul_op1 = o1[i]; spu_mul_op2 = o2[i];
      end else begin
        set_idle();
      end
      @(negedge rclk);
      if (i < 5) begin
        tests++;
        if (mul_spu_ack !== 1'b1) begin
          fails++;
          $display("FAIL accum_ack i=%0d got %0b required 1", i, mul_spu_ack);
        end
      end
      if (mul_spu_vld) begin
        tests++;
        if (n >= 5 || mul_data_out !== expd[n]) begin
          fails++;
          $display("FAIL accum_result idx=%0d got %h required %h", n, mul_data_out, n < 5 ? expd[n] : '0);
        end
        n++;
      end
    end
    tests++;
    if (n != 5) begin
      fails++;
      $display("FAIL accum_count got %0d required 5", n);
    end
    wait_drain();
  endtask

  task automatic test_overflow();
    int n = 0;
    for (int i = 0; i < 260 + LAT + 3; i++) begin
      next_cycle();
      if (i < 260) begin
        spu_mul_req = 1'b1;
        spu_mul_op  = (i == 0 || i == 259) ? 3'b100 : (i == 258) ? 3'b000 : 3'b001;
        spu_mul_op1 = (i == 258) ? 64'd1 : '1;
        spu_mul_op2 = (i == 258) ? 64'd1 : '1;
      end else begin
        set_idle();
      end
      @(negedge rclk);
      if (i < 260) begin
        tests++;
        if (mul_spu_ack !== 1'b1) begin
          fails++;
          $display("FAIL ovf_ack i=%0d got %0b required 1", i, mul_spu_ack);
        end
      end
      if (mul_spu_vld) begin
        tests++;
        if (mul_acc_ovf !== (n == 257 || n == 258)) begin
          fails++;
          $display("FAIL ovf_flag idx=%0d got %0b required %0b", n, mul_acc_ovf, n == 257 || n == 258);
        end
        n++;
      end
    end
    tests++;
    if (n != 260 || mul_acc_ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_final got strobes=%0d ovf=%0b required 260/0", n, mul_acc_ovf);
    end
    wait_drain();
  endtask

  task automatic test_reset_inflight();
    int strobes = 0;
    logic got_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      spu_mul_req = 1'b1; spu_mul_op = 3'b001; spu_mul_op1 = 64'd5; spu_mul_op2 = 64'd7;
    end
    next_cycle();
    spu_mul_req = 1'b0;
    exu_mul_req = 1'b1; exu_mul_signed = 1'b0; exu_mul_rs1 = 64'd3; exu_mul_rs2 = 64'd3;
    next_cycle();
    set_idle();
    rst_l = 1'b0;
    next_cycle();
    rst_l = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge rclk);
      if (mul_spu_vld || mul_exu_vld) strobes++;
    end
    tests++;
    if (strobes != 0) begin
      fails++;
      $display("FAIL inflight_discard got strobes=%0d required 0", strobes);
    end
    next_cycle();
    exu_mul_req = 1'b1; exu_mul_rs1 = 64'd2; exu_mul_rs2 = 64'd9;
    spu_mul_req = 1'b1; spu_mul_op = 3'b011; spu_mul_op1 = '0; spu_mul_op2 = '0;
    @(negedge rclk);
    tests++;
    if (mul_exu_ack !== 1'b1 || mul_spu_ack !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_grant got exu=%0b spu=%0b required exu=1 spu=0", mul_exu_ack, mul_spu_ack);
    end
    next_cycle();
    exu_mul_req = 1'b0;
    @(negedge rclk);
    tests++;
    if (mul_spu_ack !== 1'b1) begin
      fails++;
      $display("FAIL shr_ack got %0b required 1", mul_spu_ack);
    end
    next_cycle();
    set_idle();
    for (int i = 0; i < 20 && !got_vld; i++) begin
      @(negedge rclk);
      if (mul_spu_vld) begin
        got_vld = 1'b1;
        tests++;
        if (mul_data_out !== '0) begin
          fails++;
          $display("FAIL acc_after_reset got %h required 0", mul_data_out);
        end
      end
    end
    tests++;
    if (!got_vld) begin
      fails++;
      $display("FAIL shr_strobe_timeout got none required one");
    end
    wait_drain();
  endtask

  initial begin
    rst_l = 1'b0;
    exu_mul_req = 1'b0; exu_mul_signed = 1'b0; exu_mul_rs1 = '0; exu_mul_rs2 = '0;
    spu_mul_req = 1'b0; spu_mul_op = 3'b000; spu_mul_op1 = '0; spu_mul_op2 = '0;
    m_acc = '0;
    m_ovf = 1'b0;
    test_reset();
    test_arbitration();
    test_basic();
    test_signed();
    test_accum();
    test_overflow();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
